// File: rtl/sdiv_frontend_if.sv
// sdiv_frontend_if: bundles the operand handshake, the divider-side signals and
// the result handshake of the signed-division front end.
//   slave  : view used by sdiv_frontend
//   master : view used by whatever drives operands, models the divider and
//            consumes results
// Signals:
//   in_valid/in_ready/in_a/in_b          operand pair handshake (signed)
//   div_start/div_A/div_B                start pulse and magnitudes to divider
//   div_D/div_R/div_ok/div_err           divider results and status
//   out_valid/out_ready/out_q/out_r/out_code  signed result handshake
interface sdiv_frontend_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         div_start;
  logic [W-1:0] div_A;
  logic [W-1:0] div_B;
  logic [W-1:0] div_D;
  logic [W-1:0] div_R;
  logic         div_ok;
  logic         div_err;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_q;
  logic [W-1:0] out_r;
  logic [1:0]   out_code;

  modport slave (
    input  in_valid, in_a, in_b, div_D, div_R, div_ok, div_err, out_ready,
    output in_ready, div_start, div_A, div_B, out_valid, out_q, out_r, out_code
  );

  modport master (
    output in_valid, in_a, in_b, div_D, div_R, div_ok, div_err, out_ready,
    input  in_ready, div_start, div_A, div_B, out_valid, out_q, out_r, out_code
  );
endinterface

// File: rtl/sdiv_frontend.sv
// sdiv_frontend: signed front end for a W/W unsigned divider. Accepts a signed
// operand pair, filters divide-by-zero and the single overflowing case
// locally, otherwise issues magnitudes to the divider, waits for its result
// and sign-corrects quotient (truncating toward zero) and remainder (sign of
// dividend). A hung divider is aborted after TIMEOUT cycles.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    sdiv_frontend_if slave view (operands, divider, results)
// out_code: 00 ok, 01 divide-by-zero, 10 timeout/divider error, 11 overflow
//
// state  | meaning
// IDLE   | ready for an operand pair
// ISSUE  | div_start pulse, magnitudes on div_A/div_B
// ARM    | waiting for the divider to drop its previous div_ok
// BUSY   | waiting for div_ok / div_err
// RESP   | result held on out_* until out_ready
module sdiv_frontend #(
  parameter int W       = 32,
  parameter int TIMEOUT = 96
) (
  input logic            clk,
  input logic            reset,
  sdiv_frontend_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_BUSY, S_RESP} state_t;

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  state_t         state_q, state_d;
  logic           in_ready_q, in_ready_d;
  logic           div_start_q, div_start_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   div_a_q, div_a_d;
  logic [W-1:0]   div_b_q, div_b_d;
  logic           quot_neg_q, quot_neg_d;
  logic           rem_neg_q, rem_neg_d;
  logic [W-1:0]   res_q_q, res_q_d;
  logic [W-1:0]   res_r_q, res_r_d;
  logic [1:0]     code_q, code_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    res_q_d    = res_q_q;
    res_r_d    = res_r_q;
    code_d     = code_q;
    cnt_d      = '0;

    case (state_q)
      S_IDLE: begin
        // in_ready_q gates acceptance so nothing is taken in the cycle
        // straight after reset.
        if (in_ready_q && bus.in_valid) begin
          quot_neg_d = bus.in_a[W-1] ^ bus.in_b[W-1];
          rem_neg_d  = bus.in_a[W-1];
          if (bus.in_b == '0) begin
            res_q_d = '1;
            res_r_d = bus.in_a;
            code_d  = 2'b01;
            state_d = S_RESP;
          end else if (bus.in_a == MIN_NEG && bus.in_b == '1) begin
            res_q_d = MIN_NEG;
            res_r_d = '0;
            code_d  = 2'b11;
            state_d = S_RESP;
          end else begin
            // -MIN_NEG wraps to MIN_NEG, which is the correct unsigned magnitude.
            div_a_d = bus.in_a[W-1] ? -bus.in_a : bus.in_a;
            div_b_d = bus.in_b[W-1] ? -bus.in_b : bus.in_b;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_ARM;
      S_ARM, S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.div_err || (cnt_q == CNT_LAST &&
                            !(state_q == S_BUSY && bus.div_ok))) begin
          res_q_d = '0;
          res_r_d = '0;
          code_d  = 2'b10;
          state_d = S_RESP;
        end else if (state_q == S_ARM) begin
          if (!bus.div_ok) state_d = S_BUSY;
        end else if (bus.div_ok) begin
          res_q_d = quot_neg_q ? -bus.div_D : bus.div_D;
          res_r_d = rem_neg_q ? -bus.div_R : bus.div_R;
          code_d  = 2'b00;
          state_d = S_RESP;
        end
      end
      S_RESP: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    div_start_d = (state_d == S_ISSUE);
    out_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      div_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      quot_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
      res_q_q     <= '0;
      res_r_q     <= '0;
      code_q      <= 2'b00;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      div_start_q <= div_start_d;
      out_valid_q <= out_valid_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      quot_neg_q  <= quot_neg_d;
      rem_neg_q   <= rem_neg_d;
      res_q_q     <= res_q_d;
      res_r_q     <= res_r_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.div_start = div_start_q;
  assign bus.div_A     = div_a_q;
  assign bus.div_B     = div_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_q     = res_q_q;
  assign bus.out_r     = res_r_q;
  assign bus.out_code  = code_q;
endmodule

// File: tb/tb_sdiv_frontend.sv
module tb_sdiv_frontend;
  localparam int W       = 32;
  localparam int TIMEOUT = 96;
  localparam int LAT     = 4;

  localparam int M_OK   = 0;
  localparam int M_ERR  = 1;
  localparam int M_HANG = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sdiv_frontend_if #(.W(W)) bus();

  sdiv_frontend #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural divider: drops ok on start, answers LAT+1 edges later
  // with ok (mode OK), err (mode ERR) or never (mode HANG).
  int          mode = M_OK;
  logic        m_ok, m_err, m_busy;
  int          m_cnt;
  logic [31:0] m_d, m_r;

  assign bus.div_ok  = m_ok;
  assign bus.div_err = m_err;
  assign bus.div_D   = m_d;
  assign bus.div_R   = m_r;

  always @(posedge clk) begin
    if (reset) begin
      m_ok <= 1'b0; m_err <= 1'b0; m_busy <= 1'b0; m_cnt <= 0;
      m_d <= '0; m_r <= '0;
    end else if (bus.div_start) begin
      m_ok <= 1'b0; m_err <= 1'b0; m_busy <= 1'b1; m_cnt <= LAT;
      if (bus.div_B != 0) begin
        m_d <= bus.div_A / bus.div_B;
        m_r <= bus.div_A % bus.div_B;
      end
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0;
        if (mode == M_OK) m_ok <= 1'b1;
        else if (mode == M_ERR) m_err <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  typedef struct {
    logic [31:0] a, b;
    int          mode;
    int          hold;
    bit          start;
    logic [31:0] ea, eb;
    logic [31:0] q, r;
    logic [1:0]  code;
  } vec_t;

  typedef struct {
    logic [31:0] q, r;
    logic [1:0]  code;
  } res_t;

  res_t scb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    int   n, lat, t, starts;
    bit   seen_start, unstable, rdy_bad;
    res_t e;
    mode = v.mode;
    n = 0;
    while (!bus.in_ready && n < 50) begin step(); n++; end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_a = v.a; bus.in_b = v.b;
    scb.push_back('{v.q, v.r, v.code});
    step();
    bus.in_valid = 1'b0;
    lat = 0; t = 0; starts = 0; seen_start = 0;
    while (!bus.out_valid && lat < 1000) begin
      if (bus.div_start) begin
        if (!seen_start) begin
          chk("div_A", bus.div_A, v.ea);
          chk("div_B", bus.div_B, v.eb);
        end
        starts++; seen_start = 1; t = 0;
      end
      step(); lat++;
      if (seen_start) t++;
    end
    if (bus.div_start) starts++;
    chk("out_valid_rise", 32'(bus.out_valid), 32'd1);
    chk("start_pulses", 32'(starts), 32'(v.start));
    if (!v.start) chk("local_latency", 32'(lat), 32'd0);
    if (v.mode == M_HANG) chk("timeout_latency", 32'(t), 32'(TIMEOUT + 1));
    unstable = 0; rdy_bad = 0;
    for (int h = 0; h < v.hold; h++) begin
      bus.in_valid = 1'b1; bus.in_a = 32'd5; bus.in_b = 32'd1;
      step();
      if (!bus.out_valid || bus.out_q !== v.q || bus.out_r !== v.r || bus.out_code !== v.code)
        unstable = 1;
      if (bus.in_ready || bus.div_start) rdy_bad = 1;
    end
    if (v.hold > 0) begin
      chk("hold_stable", 32'(unstable), 32'd0);
      chk("hold_no_accept", 32'(rdy_bad), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("scb_nonempty", 32'(scb.size()), 32'd1);
    if (scb.size() > 0) begin
      e = scb.pop_front();
      chk("out_q", bus.out_q, e.q);
      chk("out_r", bus.out_r, e.r);
      chk("out_code", 32'(bus.out_code), 32'(e.code));
    end
    step();
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t              v;
    logic signed [31:0] sa, sbv;
    int                n;

    //          a             b             mode    hold start ea            eb            q             r             code
    vecs[0]  = '{32'd7,        32'd3,        M_OK,   3,  1, 32'd7,        32'd3,        32'd2,        32'd1,        2'b00};
    vecs[1]  = '{32'hFFFFFFC4, 32'd7,        M_OK,   0,  1, 32'd60,       32'd7,        32'hFFFFFFF8, 32'hFFFFFFFC, 2'b00};
    vecs[2]  = '{32'd82,       32'hFFFFFFFA, M_OK,   0,  1, 32'd82,       32'd6,        32'hFFFFFFF3, 32'd4,        2'b00};
    vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, M_OK,   0,  1, 32'd100,      32'd7,        32'd14,       32'hFFFFFFFE, 2'b00};
    vecs[4]  = '{32'h0000000D, 32'd0,        M_OK,   2,  0, 32'd0,        32'd0,        32'hFFFFFFFF, 32'h0000000D, 2'b01};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, M_OK,   0,  0, 32'd0,        32'd0,        32'h80000000, 32'd0,        2'b11};
    vecs[6]  = '{32'h64,       32'd7,        M_OK,   10, 1, 32'h64,       32'd7,        32'd14,       32'd2,        2'b00};
    vecs[7]  = '{32'd56,       32'd7,        M_HANG, 0,  1, 32'd56,       32'd7,        32'd0,        32'd0,        2'b10};
    vecs[8]  = '{32'd56,       32'd7,        M_ERR,  0,  1, 32'd56,       32'd7,        32'd0,        32'd0,        2'b10};
    vecs[9]  = '{32'h80000000, 32'd2,        M_OK,   0,  1, 32'h80000000, 32'd2,        32'hC0000000, 32'd0,        2'b00};
    vecs[10] = '{32'hFFFFFFF9, 32'd0,        M_OK,   0,  0, 32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 2'b01};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;

    repeat (3) step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_div_start", 32'(bus.div_start), 32'd0);
    chk("rst_div_A", bus.div_A, 32'd0);
    chk("rst_div_B", bus.div_B, 32'd0);
    chk("rst_out_q", bus.out_q, 32'd0);
    chk("rst_out_r", bus.out_r, 32'd0);
    chk("rst_out_code", 32'(bus.out_code), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) run_op(vecs[i]);

    // Random non-trivial operands checked against SV signed arithmetic.
    for (int i = 0; i < 6; i++) begin
      sa  = $urandom;
      sbv = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 50));
      if (i % 3 == 1) sbv = -sbv;
      if (sbv == 0) sbv = 3;
      if (sa == 32'sh80000000 && sbv == -1) sbv = 5;
      v.a = sa; v.b = sbv; v.mode = M_OK; v.hold = 0; v.start = 1;
      v.ea = sa[31] ? -sa : sa;
      v.eb = sbv[31] ? -sbv : sbv;
      v.q = sa / sbv;
      v.r = sa % sbv;
      v.code = 2'b00;
      run_op(v);
    end

    // Reset while the divider is busy: no result, clean restart.
    mode = M_HANG;
    n = 0;
    while (!bus.in_ready && n < 50) begin step(); n++; end
    bus.in_valid = 1'b1; bus.in_a = 32'd56; bus.in_b = 32'd7;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_div_start", 32'(bus.div_start), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    step();
    chk("midrst_in_ready_after", 32'(bus.in_ready), 32'd1);
    v = '{32'h6E, 32'd7, M_OK, 0, 1, 32'h6E, 32'd7, 32'd15, 32'd5, 2'b00};
    run_op(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdiv_frontend.md
Name: sdiv_frontend

Overview:
Signed-division front end that sits directly upstream of the 32/32 unsigned divider. It accepts signed operand pairs over a valid/ready handshake, converts them to magnitudes and pulses the divider's start. It then waits for ok/err and sign-corrects quotient and remainder. Results are held for a downstream consumer with valid/ready. It also filters divide-by-zero locally and guards against a hung divider with a timeout.

Parameters:
W, 32, operand/result width (must match divider)
TIMEOUT, 96, max cycles in BUSY before aborting with timeout error

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  front end can accept (high only in IDLE)
in_a  input  W  signed dividend (two's complement)
in_b  input  W  signed divisor (two's complement)
div_start  output  1  one-cycle start pulse to divider
div_A  output  W  unsigned dividend magnitude to divider
div_B  output  W  unsigned divisor magnitude to divider
div_D  input  W  divider quotient
div_R  input  W  divider remainder
div_ok  input  1  divider result ready (level)
div_err  input  1  divider error
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_q  output  W  signed quotient
out_r  output  W  signed remainder
out_code  output  2  00 ok, 01 divide-by-zero, 10 timeout/divider error, 11 overflow

Behaviour:
- Reset values: in_ready=0 during reset and 1 the cycle after; div_start=0; div_A=div_B=0; out_valid=0; out_q=out_r=0; out_code=00; FSM=IDLE; timeout counter=0. Reset mid-operation aborts with no output. A pending out_valid is dropped.
- FSM states: IDLE, ISSUE, ARM, BUSY, RESP.
- IDLE: in_ready=1. On in_valid, latch in_a, in_b, sign_q=a[W-1]^b[W-1] and sign_r=a[W-1].
  - If in_b==0: go to RESP with out_q=all ones, out_r=in_a, code=01. The divider is not started.
  - Else if in_a==0x80000000 and in_b==0xFFFFFFFF: go to RESP with out_q=0x80000000, out_r=0, code=11. The divider is not started.
  - Else: load div_A=|in_a| and div_B=|in_b|. |x| of 0x80000000 is 0x80000000 unsigned. Go to ISSUE.
- ISSUE: div_start=1 for exactly this one cycle, then go to ARM. div_A and div_B stay stable from ISSUE until leaving BUSY.
- ARM: wait for div_ok==0, i.e. the divider has cleared the previous result, then go to BUSY.
  - If div_err==1 here, go to RESP with code=10.
  - ARM counts toward the timeout.
- BUSY: on the first cycle with div_ok==1, compute:
  - out_q = sign_q ? -div_D : div_D
  - out_r = sign_r ? -div_R : div_R
  - code=00, go to RESP.
  - div_err==1 (priority over div_ok) → RESP with code=10 and out_q=out_r=0.
- Timeout: the counter runs in ARM and BUSY and clears on IDLE. When it reaches TIMEOUT-1 with no completion, go to RESP with code=10 and out_q=out_r=0.
- RESP: out_valid=1. Outputs are held stable until out_ready is sampled high. On that edge out_valid=0 and the FSM returns to IDLE.
- Throughput: no new operand is accepted until the previous result is consumed (in_ready=0 outside IDLE).
- Latency: for a non-trivial input, the result appears 3 cycles plus the divider's ok latency after acceptance. For local div0/overflow, out_valid rises 1 cycle after acceptance.
- Semantics: truncating division toward zero. The remainder takes the sign of the dividend, so a = q*b + r always holds for code 00.
- out_ready is ignored when out_valid=0. in_valid is ignored when in_ready=0.

Test Plan:
- Reset, then in_a=7, in_b=3 → div_start is a single pulse with div_A=7, div_B=3; out_q=2, out_r=1, code=00; out_valid holds until out_ready.
- in_a=-60 (0xFFFFFFC4), in_b=7 → div_A=60; out_q=-8 (0xFFFFFFF8), out_r=-4 (0xFFFFFFFC). Then in_a=82, in_b=-6 → out_q=-13, out_r=4. Then in_a=-100, in_b=-7 → out_q=14, out_r=-2.
- in_a=0x0D, in_b=0 → no div_start; out_valid one cycle after accept; out_q=0xFFFFFFFF, out_r=0x0D, code=01. Then in_a=0x80000000, in_b=0xFFFFFFFF → out_q=0x80000000, out_r=0, code=11, no div_start.
- Stub divider that never raises div_ok, in_a=56, in_b=7 → exactly TIMEOUT cycles after ARM entry, out_valid=1 with code=10 and out_q=out_r=0. Also: stub asserting div_err in BUSY → code=10.
- Backpressure: hold out_ready=0 for 10 cycles with 0x64/0x07 pending → out_q=14, out_r=2 stay stable; in_ready=0; a second in_valid is not accepted until out_ready is pulsed.
- Assert reset in BUSY → the next cycle has out_valid=0 and div_start=0, and in_ready=1 after reset deasserts. The following 0x6E/0x07 → q=15, r=5.
